// File: rtl/pipe_stage_mem_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_mem_pkg
//   Shared types and constants for the memory pipeline stage.
//   - mem_state_e : bus-access state machine encoding (IDLE / BUSY)
//   - m_reg_t     : EXE/MEM pipeline register contents
//   - w_reg_t     : MEM/WB pipeline register contents
//   - M_BUBBLE / W_BUBBLE : all-zero "no instruction" values
//   - ABORT_DATA  : load data written back for an aborted access
// ---------------------------------------------------------------------------
package pipe_stage_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  localparam logic [31:0] ABORT_DATA = 32'h0;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
  } m_reg_t;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
  } w_reg_t;

  localparam m_reg_t M_BUBBLE = '0;
  localparam w_reg_t W_BUBBLE = '0;

  // Word accesses only: any memory op whose address is not 4-byte aligned
  // is rejected without touching the bus.
  function automatic logic is_misaligned(input logic mem_op, input logic [31:0] addr);
    return mem_op & (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pipe_mem_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_mem_ctrl
//   Bus-access controller for the memory stage: request generation, wait
//   tracking with a timeout counter, pipeline stall and abort reporting.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no access outstanding; a new access may complete with zero wait
//   BUSY  | access issued, waiting for dmem_ready; cnt counts waited cycles
//
//   Ports:
//     clock, resetn   - clock, async active-low reset
//     mem_op_i        - M-stage instruction is a load or store
//     misaligned_i    - M-stage memory op has a non-word-aligned address
//     dmem_ready_i    - memory completes the access this cycle
//     mstall_o        - hold upstream pipeline and the M register
//     dmem_req_o      - bus request
//     mem_err_o       - access aborted this cycle (misaligned or timeout)
// ---------------------------------------------------------------------------
module pipe_mem_ctrl
  import pipe_stage_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic mem_op_i,
  input  logic misaligned_i,
  input  logic dmem_ready_i,
  output logic mstall_o,
  output logic dmem_req_o,
  output logic mem_err_o
);

  // Last wait cycle before the access is abandoned; the IDLE cycle that
  // issues the request counts as cycle 0, so the abort lands on cycle
  // TIMEOUT-1 of the request (the TIMEOUT-th cycle overall).
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req;

  // The request follows the M register directly, so address, data and
  // write enable cannot change while the stage is stalled.
  assign req        = mem_op_i & ~misaligned_i;
  assign dmem_req_o = req;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mstall_o  = 1'b0;
    mem_err_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op_i && misaligned_i) begin
          mem_err_o = 1'b1;
        end else if (req && !dmem_ready_i) begin
          mstall_o = 1'b1;
          state_d  = BUSY;
          cnt_d    = 8'd1;
        end
      end

      BUSY: begin
        // Ready is tested first so a late response on the final wait
        // cycle still completes normally.
        if (dmem_ready_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q < CNT_LAST) begin
          mstall_o = 1'b1;
          cnt_d    = cnt_q + 8'd1;
        end else begin
          mem_err_o = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_stage_mem.sv
// ---------------------------------------------------------------------------
// pipe_stage_mem
//   Memory pipeline stage: EXE/MEM register, data-memory bus master with a
//   ready handshake, stall/abort control and the MEM/WB register.
//
//   Ports:
//     clock, resetn                 - clock, async active-low reset
//     ewreg, em2reg, ewmem          - EXE control: reg write, load, store
//     ealu, eb, ern                 - EXE result/address, store data, dest
//     mstall                        - freeze PC and IF/ID/EXE this cycle
//     mwreg, mm2reg, malu, mrn      - M-stage values for forwarding
//     dmem_req, dmem_we             - bus request and write enable
//     dmem_addr, dmem_wdata         - bus word address and store data
//     dmem_rdata, dmem_ready        - bus load data and completion
//     wwreg, wm2reg, wmo, walu, wrn - MEM/WB register outputs
//     mem_err                       - one-cycle pulse on an aborted access
// ---------------------------------------------------------------------------
module pipe_stage_mem
  import pipe_stage_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  output logic        mstall,
  output logic        mwreg,
  output logic        mm2reg,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        mem_err
);

  m_reg_t m_q, m_d;
  w_reg_t w_q, w_d;

  logic mem_op;
  logic misaligned;
  logic load_done;
  logic stall;
  logic req;
  logic err;

  // ---------------- EXE/MEM register ----------------
  assign m_d = {ewreg, em2reg, ewmem, ealu, eb, ern};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_q <= M_BUBBLE;
    end else if (!stall) begin
      m_q <= m_d;
    end
  end

  assign mem_op     = m_q.m2reg | m_q.wmem;
  assign misaligned = is_misaligned(mem_op, m_q.alu);

  // ---------------- bus controller ----------------
  pipe_mem_ctrl #(
    .TIMEOUT (TIMEOUT)
  ) u_ctrl (
    .clock        (clock),
    .resetn       (resetn),
    .mem_op_i     (mem_op),
    .misaligned_i (misaligned),
    .dmem_ready_i (dmem_ready),
    .mstall_o     (stall),
    .dmem_req_o   (req),
    .mem_err_o    (err)
  );

  // Ready only counts while a request is on the bus.
  assign load_done = req & dmem_ready & m_q.m2reg;

  // ---------------- MEM/WB register ----------------
  // A stalled cycle writes a bubble so write-back sees each instruction
  // exactly once; an aborted access keeps its slot but loses its reg write.
  always_comb begin
    w_d = W_BUBBLE;
    if (!stall) begin
      w_d.wreg  = m_q.wreg & ~err;
      w_d.m2reg = m_q.m2reg;
      w_d.mo    = load_done ? dmem_rdata : ABORT_DATA;
      w_d.alu   = m_q.alu;
      w_d.rn    = m_q.rn;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      w_q <= W_BUBBLE;
    end else begin
      w_q <= w_d;
    end
  end

  // ---------------- outputs ----------------
  assign mstall     = stall;
  assign mem_err    = err;

  assign mwreg      = m_q.wreg;
  assign mm2reg     = m_q.m2reg;
  assign malu       = m_q.alu;
  assign mrn        = m_q.rn;

  assign dmem_req   = req;
  assign dmem_we    = m_q.wmem;
  assign dmem_addr  = m_q.alu;
  assign dmem_wdata = m_q.b;

  assign wwreg      = w_q.wreg;
  assign wm2reg     = w_q.m2reg;
  assign wmo        = w_q.mo;
  assign walu       = w_q.alu;
  assign wrn        = w_q.rn;

endmodule
